gameport_sampler: RTL and testbench
===================================

// Module: gameport_sampler
// PURPOSE
//  Host side of the PC game port: fires the external 558 one-shot trigger, times each of the
//  four axis lines, and converts the widths to signed 8-bit analog values and digital
//  direction/button bits. Outputs use the ana_x/dig_x packing consumed by the game port
//  emulator, so a physical analog stick on GPIO can drive the ao486 joystick port.
// PARAMETERS
//  CLK_DIV     266  clk cycles per measurement tick (one tick = one count unit)
//  TRIG_LEN    16   clk cycles gp_trig is held high
//  TIMEOUT     511  tick count at which an axis still high is declared unconnected
//  GAP_TICKS   1024 ticks idle between end of one conversion and next trigger
//  DIR_THRESH  64   |analog| above which a direction bit is set
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   synchronous, active-low reset
//  enable    in   1   1 = run sampling cycles continuously
//  gp_trig   out  1   trigger to external one-shots, active high
//  gp_axis   in   4   async one-shot outputs {J2Y,J2X,J1Y,J1X}, high while timing
//  gp_btn_n  in   4   async buttons {J2B2,J2B1,J1B2,J1B1}, active low
//  ana_1     out  16  {J1Y[7:0],J1X[7:0]} signed
//  ana_2     out  16  {J2Y[7:0],J2X[7:0]} signed
//  dig_1     out  6   {B2,B1,UP,DOWN,LEFT,RIGHT} joystick 1, active high
//  dig_2     out  6   same packing, joystick 2
//  timeout   out  4   per-axis unconnected flag, order as gp_axis
//  valid     out  1   one-clk pulse when outputs update
// BEHAVIOUR
//  - Reset: state IDLE; gp_trig=0, ana_*=0, dig_*=0, timeout=0, valid=0, counters=0.
//  - gp_axis, gp_btn_n pass 2-FF synchronisers; all logic below uses synced values.
//  - FSM IDLE: enable=1 -> TRIG; enable=0 -> stay.
//  - TRIG: gp_trig=1 for exactly TRIG_LEN clks; clear tick counter, divider and per-axis
//    done flags; sample buttons (sample A) -> MEASURE.
//  - MEASURE: divider counts 0..CLK_DIV-1, tick when divider==CLK_DIV-1.
//    Any axis low and not done -> capture current tick count, set done.
//    Axis low on first MEASURE clk -> count 0.
//    Tick: tick count +1, saturating at TIMEOUT.
//    All four done, or tick count==TIMEOUT -> CONVERT. Undone axes: count=TIMEOUT, timeout=1.
//  - CONVERT (1 clk): register all outputs, valid=1, sample buttons (sample B) -> GAP.
//    Per axis: d = count - 200 (signed 10b); a = (d*171)>>>8 (arith, floor); clamp to [-128,127].
//    Timed-out axis: a = 0, its direction bits 0.
//    RIGHT = X > DIR_THRESH, LEFT = X < -DIR_THRESH; DOWN = Y > DIR_THRESH, UP = Y < -DIR_THRESH.
//    Button bit = 1 iff pressed (low) in both sample A and sample B; else 0.
//  - GAP: count GAP_TICKS ticks, then -> TRIG if enable=1, else IDLE.
//  - enable dropped mid-cycle: finish through CONVERT/GAP, then IDLE. Outputs hold last values.
//  - rst_n low in any state: next clk all reset values; gp_trig falls immediately, no partial
//    conversion emitted.
//  - Outputs change only in CONVERT; stable between valid pulses.
// TESTING
//  1 Model axes fall 200 ticks after gp_trig falls, no buttons -> ana_1=ana_2=0, dig=0,
//    timeout=0, one valid pulse.
//  2 J1X falls at tick 8, J1Y at tick 391 -> ana_1[7:0]=0x80 (-128), ana_1[15:8]=0x7F,
//    dig_1=6'b000110 (DOWN, LEFT).
//  3 J2X falls at tick 350 -> ana_2[7:0]=100 (0x64), dig_2[0]=1. J2Y held high ->
//    timeout=4'b1000, ana_2[15:8]=0, valid after TIMEOUT ticks.
//  4 J1B1 low for entire cycle -> dig_1[4]=1. J1B2 low only at trigger -> dig_1[5]=0.
//  5 rst_n low during MEASURE -> next clk gp_trig=0, outputs 0, no valid.
//    Restart yields normal cycle.
//  6 enable deasserted during MEASURE -> valid pulses once, FSM reaches IDLE,
//    no further gp_trig pulses.

Source files
------------

// File: rtl/gameport_sampler.sv
// PC game port host sampler: fires the 558 one-shots, times the four axis pulses and
// converts the widths to signed analog values plus direction/button bits.
module gameport_sampler #(
    parameter int CLK_DIV    = 266,
    parameter int TRIG_LEN   = 16,
    parameter int TIMEOUT    = 511,
    parameter int GAP_TICKS  = 1024,
    parameter int DIR_THRESH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        gp_trig,
    input  logic [3:0]  gp_axis,
    input  logic [3:0]  gp_btn_n,
    output logic [15:0] ana_1,
    output logic [15:0] ana_2,
    output logic [5:0]  dig_1,
    output logic [5:0]  dig_2,
    output logic [3:0]  timeout,
    output logic        valid,
    output logic [2:0]  dbg_state_o
);

    localparam int DW  = $clog2(CLK_DIV);
    localparam int TLW = $clog2(TRIG_LEN);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int GW  = $clog2(GAP_TICKS);
    localparam logic signed [7:0] THR = 8'(DIR_THRESH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG    = 3'd1,
        S_MEASURE = 3'd2,
        S_CONVERT = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    // Handshake: valid is a one-clock strobe with no ready; the outputs it qualifies hold
    // their values until the next strobe, so a consumer may sample them at any time.

    state_t                 state_q, state_d;
    logic [3:0]             axis_s1_q, axis_s2_q;
    logic [3:0]             btn_s1_q, btn_s2_q;
    logic [TLW-1:0]         trig_cnt_q, trig_cnt_d;
    logic [DW-1:0]          div_q, div_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [3:0]             done_q, done_d;
    logic [3:0][TW-1:0]     cnt_q, cnt_d;
    logic [3:0]             btn_a_q, btn_a_d;
    logic                   gp_trig_q, gp_trig_d;
    logic [3:0][7:0]        ana_q, ana_d;
    logic [5:0]             dig_1_q, dig_1_d, dig_2_q, dig_2_d;
    logic [3:0]             timeout_q, timeout_d;
    logic                   valid_q, valid_d;

    logic                   tick;
    logic [3:0][7:0]        ana_v;
    logic [3:0]             pressed;

    // Width -> signed value: (count - 200) * 171 / 256 with floor, clamped to 8 bits.
    function automatic logic [7:0] to_analog(input logic [TW-1:0] cnt);
        logic signed [17:0] d, p, s;
        d = $signed(18'(cnt)) - 18'sd200;
        p = d * 18'sd171;
        s = p >>> 8;
        if (s > 18'sd127)
            return 8'h7F;
        else if (s < -18'sd128)
            return 8'h80;
        else
            return s[7:0];
    endfunction

    // Returns {UP, DOWN, LEFT, RIGHT}.
    function automatic logic [3:0] dir_bits(input logic [7:0] x, input logic [7:0] y);
        return {$signed(y) < -THR, $signed(y) > THR, $signed(x) < -THR, $signed(x) > THR};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            axis_s1_q  <= '0;
            axis_s2_q  <= '0;
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            trig_cnt_q <= '0;
            div_q      <= '0;
            tick_q     <= '0;
            gap_q      <= '0;
            done_q     <= '0;
            cnt_q      <= '0;
            btn_a_q    <= '0;
            gp_trig_q  <= 1'b0;
            ana_q      <= '0;
            dig_1_q    <= '0;
            dig_2_q    <= '0;
            timeout_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            axis_s1_q  <= gp_axis;
            axis_s2_q  <= axis_s1_q;
            btn_s1_q   <= gp_btn_n;
            btn_s2_q   <= btn_s1_q;
            trig_cnt_q <= trig_cnt_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            gap_q      <= gap_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            btn_a_q    <= btn_a_d;
            gp_trig_q  <= gp_trig_d;
            ana_q      <= ana_d;
            dig_1_q    <= dig_1_d;
            dig_2_q    <= dig_2_d;
            timeout_q  <= timeout_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        trig_cnt_d = trig_cnt_q;
        div_d      = div_q;
        tick_d     = tick_q;
        gap_d      = gap_q;
        done_d     = done_q;
        cnt_d      = cnt_q;
        btn_a_d    = btn_a_q;
        ana_d      = ana_q;
        dig_1_d    = dig_1_q;
        dig_2_d    = dig_2_q;
        timeout_d  = timeout_q;
        valid_d    = 1'b0;
        tick       = (div_q == DW'(CLK_DIV - 1));
        pressed    = btn_a_q & ~btn_s2_q;
        ana_v      = '0;
        for (int k = 0; k < 4; k++) begin
            // Axes that never fell report centre so they produce no direction bits.
            ana_v[k] = done_q[k] ? to_analog(cnt_q[k]) : 8'h00;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d    = S_TRIG;
                    trig_cnt_d = '0;
                end
            end
            S_TRIG: begin
                trig_cnt_d = trig_cnt_q + 1'b1;
                div_d      = '0;
                tick_d     = '0;
                done_d     = '0;
                if (trig_cnt_q == TLW'(TRIG_LEN - 1)) begin
                    btn_a_d = ~btn_s2_q;
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                div_d = tick ? '0 : div_q + 1'b1;
                for (int k = 0; k < 4; k++) begin
                    if (!axis_s2_q[k] && !done_q[k]) begin
                        done_d[k] = 1'b1;
                        cnt_d[k]  = tick_q;
                    end
                end
                if (tick && tick_q != TW'(TIMEOUT))
                    tick_d = tick_q + 1'b1;
                if (&done_q || tick_q == TW'(TIMEOUT))
                    state_d = S_CONVERT;
            end
            S_CONVERT: begin
                ana_d     = ana_v;
                timeout_d = ~done_q;
                dig_1_d   = {pressed[1], pressed[0], dir_bits(ana_v[0], ana_v[1])};
                dig_2_d   = {pressed[3], pressed[2], dir_bits(ana_v[2], ana_v[3])};
                valid_d   = 1'b1;
                div_d     = '0;
                gap_d     = '0;
                state_d   = S_GAP;
            end
            S_GAP: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    if (gap_q == GW'(GAP_TICKS - 1)) begin
                        state_d    = enable ? S_TRIG : S_IDLE;
                        trig_cnt_d = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        gp_trig_d = (state_d == S_TRIG);
    end

    assign gp_trig     = gp_trig_q;
    assign ana_1       = {ana_q[1], ana_q[0]};
    assign ana_2       = {ana_q[3], ana_q[2]};
    assign dig_1       = dig_1_q;
    assign dig_2       = dig_2_q;
    assign timeout     = timeout_q;
    assign valid       = valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gameport_sampler.sv
// Bench for gameport_sampler: emulates the 558 one-shots and buttons, predicts each
// conversion from fall times with plain integer arithmetic and scores every valid strobe.
module tb_gameport_sampler;

    localparam int CLK_DIV   = 4;
    localparam int TIMEOUT   = 511;
    localparam int GAP_TICKS = 16;
    localparam int W         = 48;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        gp_trig;
    logic [3:0]  gp_axis = 4'h0;
    logic [3:0]  gp_btn_n = 4'hF;
    logic [15:0] ana_1, ana_2;
    logic [5:0]  dig_1, dig_2;
    logic [3:0]  timeout;
    logic        valid;
    logic [2:0]  dbg_state;

    int n_total = 0;
    int n_bad   = 0;
    logic [W-1:0] exp_q[$];

    // Per-axis fall time in ticks after trigger (-1 = unconnected), buttons at trigger/end.
    int         cfg_n[4];
    logic [3:0] cfg_bt = 4'hF;
    logic [3:0] cfg_be = 4'hF;
    int         c = 100000;

    gameport_sampler #(
        .CLK_DIV(CLK_DIV), .TRIG_LEN(16), .TIMEOUT(TIMEOUT),
        .GAP_TICKS(GAP_TICKS), .DIR_THRESH(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .gp_trig(gp_trig),
        .gp_axis(gp_axis), .gp_btn_n(gp_btn_n), .ana_1(ana_1), .ana_2(ana_2),
        .dig_1(dig_1), .dig_2(dig_2), .timeout(timeout), .valid(valid),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // One-shot and button emulation, stepped on the inactive edge.
    always @(negedge clk) begin
        if (gp_trig) begin
            c = 0;
            gp_btn_n = cfg_bt;
        end else begin
            c = c + 1;
        end
        if (c == 3) gp_btn_n = cfg_be;
        for (int k = 0; k < 4; k++)
            gp_axis[k] = (cfg_n[k] < 0) ? 1'b1 : (c < cfg_n[k] * CLK_DIV - 1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int axis_val(input int n);
        int v, q;
        if (n < 0) return 0;
        v = (n - 200) * 171;
        q = (v >= 0) ? v / 256 : -((-v + 255) / 256);
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    function automatic logic [W-1:0] model();
        int         a[4];
        logic [3:0] to, pr;
        logic [5:0] d1, d2;
        for (int k = 0; k < 4; k++) begin
            a[k]  = axis_val(cfg_n[k]);
            to[k] = (cfg_n[k] < 0);
        end
        pr = ~cfg_bt & ~cfg_be;
        d1 = {pr[1], pr[0], a[1] < -64, a[1] > 64, a[0] < -64, a[0] > 64};
        d2 = {pr[3], pr[2], a[3] < -64, a[3] > 64, a[2] < -64, a[2] > 64};
        return {8'(a[3]), 8'(a[2]), 8'(a[1]), 8'(a[0]), d2, d1, to};
    endfunction

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        check("valid_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_trig_fall();
        bit hi = 1'b0, lo = 1'b0;
        for (int i = 0; i < 3000 && !lo; i++) begin
            @(negedge clk);
            if (gp_trig) hi = 1'b1;
            else if (hi) lo = 1'b1;
        end
        check("trig_fall_seen", 32'(lo), 32'd1);
    endtask

    task automatic score_outputs();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("ana_1", 32'(ana_1), 32'(e[31:16]));
            check("ana_2", 32'(ana_2), 32'(e[47:32]));
            check("dig_1", 32'(dig_1), 32'(e[9:4]));
            check("dig_2", 32'(dig_2), 32'(e[15:10]));
            check("timeout", 32'(timeout), 32'(e[3:0]));
        end
    endtask

    task automatic run_case();
        bit seen;
        exp_q.push_back(model());
        wait_valid(seen);
        if (seen) begin
            score_outputs();
            @(negedge clk);
            check("valid_pulse_width", 32'(valid), 32'd0);
        end
    endtask

    task automatic set_axes(input int a0, input int a1, input int a2, input int a3,
                            input logic [3:0] bt, input logic [3:0] be);
        cfg_n[0] = a0; cfg_n[1] = a1; cfg_n[2] = a2; cfg_n[3] = a3;
        cfg_bt = bt; cfg_be = be;
    endtask

    task automatic set_random();
        for (int k = 0; k < 4; k++)
            cfg_n[k] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(5, 480));
        cfg_bt = 4'($urandom);
        cfg_be = 4'($urandom);
    endtask

    initial begin
        int trig_hi;
        bit seen;
        rst_n  = 1'b0;
        enable = 1'b0;
        set_axes(200, 200, 200, 200, 4'hF, 4'hF);
        repeat (3) @(negedge clk);
        check("rst_trig", 32'(gp_trig), 32'd0);
        check("rst_ana", 32'({ana_2, ana_1}), 32'd0);
        check("rst_dig", 32'({dig_2, dig_1}), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_no_trig", 32'(gp_trig), 32'd0);
        check("idle_state", 32'(dbg_state), 32'd0);

        // Centred sticks, no buttons.
        enable = 1'b1;
        run_case();
        // Full-scale left on J1X, full-scale down on J1Y.
        set_axes(8, 391, 200, 200, 4'hF, 4'hF);
        run_case();
        // J2X right, J2Y unconnected.
        set_axes(200, 200, 350, -1, 4'hF, 4'hF);
        run_case();
        // J1B1 held whole cycle, J1B2 only at trigger.
        set_axes(200, 200, 200, 200, 4'b1100, 4'b1110);
        run_case();
        // Axis already low on the first measurement clock.
        set_axes(0, 200, 120, 280, 4'b0101, 4'b0001);
        run_case();
        for (int r = 0; r < 8; r++) begin
            set_random();
            run_case();
        end

        // Reset in the middle of a measurement.
        set_axes(300, 100, 250, 50, 4'h0, 4'h0);
        wait_trig_fall();
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_trig", 32'(gp_trig), 32'd0);
        check("mrst_ana", 32'({ana_2, ana_1}), 32'd0);
        check("mrst_dig", 32'({dig_2, dig_1}), 32'd0);
        check("mrst_timeout", 32'(timeout), 32'd0);
        check("mrst_state", 32'(dbg_state), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("mrst_valid", 32'(valid), 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        run_case();

        // Drop enable mid-measurement: one more result, then idle for good.
        set_axes(300, 150, 60, 420, 4'b1010, 4'b1000);
        exp_q.push_back(model());
        wait_trig_fall();
        repeat (20) @(negedge clk);
        enable = 1'b0;
        wait_valid(seen);
        if (seen) score_outputs();
        trig_hi = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (gp_trig || valid) trig_hi++;
        end
        check("no_retrigger", 32'(trig_hi), 32'd0);
        check("final_idle", 32'(dbg_state), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
